seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_muldiv_iter.sv | 89 ++++++++
 rtl/seq_alu.sv | 231 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, control FSM states
// and the bundle of status flags that travels with every result.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_SHL1 = 4'b1010;
    localparam logic [3:0] OP_SHR1 = 4'b1011;
    localparam logic [3:0] OP_ROR1 = 4'b1100;
    localparam logic [3:0] OP_ROL1 = 4'b1101;
    localparam logic [3:0] OP_EQ   = 4'b1110;
    localparam logic [3:0] OP_GT   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic c_out;
        logic zero;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per
// clock. The first iteration is applied on the start edge itself so the
// full result is ready WIDTH-1 edges later and the parent can register it
// on the following edge.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             div_mode,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    logic             busy_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] op_r;
    logic             div_r;

    // One iteration: hi holds partial product / remainder, lo holds the
    // multiplier / dividend being shifted out (and the quotient shifted in).
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo,
                                                input logic [WIDTH-1:0] op,
                                                input logic             div);
        logic [WIDTH:0]     sum;
        logic [WIDTH:0]     shifted;
        logic [WIDTH:0]     diff;
        logic [2*WIDTH-1:0] r;
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, op} : {(WIDTH+1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, op};
        if (div) begin
            if (shifted >= {1'b0, op}) begin
                r = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end else begin
                r = {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            r = {sum, lo[WIDTH-1:1]};
        end
        return r;
    endfunction

    // Load operands with the first iteration applied, then iterate until
    // the count reaches WIDTH, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            op_r   <= {WIDTH{1'b0}};
            div_r  <= 1'b0;
        end else if (start) begin
            busy_r       <= 1'b1;
            cnt_r        <= CNT_ONE;
            {hi_r, lo_r} <= step({WIDTH{1'b0}}, a, b, is_div);
            op_r         <= b;
            div_r        <= is_div;
        end else if (busy_r) begin
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r        <= cnt_r + CNT_ONE;
                {hi_r, lo_r} <= step(hi_r, lo_r, op_r, div_r);
            end
        end
    end

    assign done     = busy_r & (cnt_r == CNT_LAST);
    assign div_mode = div_r;
    assign res_lo   = lo_r;
    assign res_hi   = hi_r;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle
// ops complete on the accept edge; MUL/DIV run on the iterative engine.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             c_out,
    output logic             zero,
    output logic             err
);

    localparam logic MD_ON = (MUL_DIV_EN != 0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    flags_t           flags_r;

    logic             accept_s;
    logic             div_zero_s;
    logic             start_s;
    logic             is_div_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] sc_res_s;
    logic [WIDTH-1:0] sc_hi_s;
    logic             sc_c_s;
    logic             sc_err_s;
    logic             md_done_s;
    logic             md_div_s;
    logic [WIDTH-1:0] md_lo_s;
    logic [WIDTH-1:0] md_hi_s;
    logic             ld_en_s;
    logic [WIDTH-1:0] ld_res_s;
    logic [WIDTH-1:0] ld_hi_s;
    flags_t           ld_flags_s;

    assign accept_s   = in_valid & in_ready_r;
    assign div_zero_s = (b == {WIDTH{1'b0}});
    assign is_div_s   = (opcode == OP_DIV);
    assign start_s    = accept_s & MD_ON & ((opcode == OP_MUL) | (is_div_s & ~div_zero_s));
    assign add_s      = {1'b0, a} + {1'b0, b};
    assign sub_s      = {1'b0, a} - {1'b0, b};

    if (MUL_DIV_EN != 0) begin : g_md
        alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_s),
            .is_div   (is_div_s),
            .a        (a),
            .b        (b),
            .done     (md_done_s),
            .div_mode (md_div_s),
            .res_lo   (md_lo_s),
            .res_hi   (md_hi_s)
        );
    end else begin : g_no_md
        assign md_done_s = 1'b0;
        assign md_div_s  = 1'b0;
        assign md_lo_s   = {WIDTH{1'b0}};
        assign md_hi_s   = {WIDTH{1'b0}};
    end

    // Single-cycle datapath, including the no-BUSY MUL/DIV corner cases.
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        sc_hi_s  = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        sc_err_s = 1'b0;
        case (opcode)
            OP_AND:  sc_res_s = a & b;
            OP_OR:   sc_res_s = a | b;
            OP_XOR:  sc_res_s = a ^ b;
            OP_NAND: sc_res_s = ~(a & b);
            OP_NOR:  sc_res_s = ~(a | b);
            OP_XNOR: sc_res_s = ~(a ^ b);
            OP_ADD: begin
                sc_res_s = add_s[WIDTH-1:0];
                sc_c_s   = add_s[WIDTH];
            end
            OP_SUB: begin
                sc_res_s = sub_s[WIDTH-1:0];
                sc_c_s   = sub_s[WIDTH];
            end
            OP_MUL:  sc_err_s = ~MD_ON;
            OP_DIV: begin
                if (!MD_ON) begin
                    sc_err_s = 1'b1;
                end else if (div_zero_s) begin
                    sc_res_s = {WIDTH{1'b1}};
                    sc_hi_s  = a;
                    sc_err_s = 1'b1;
                end else begin
                    sc_err_s = 1'b0;
                end
            end
            OP_SHL1: begin
                sc_res_s = {a[WIDTH-2:0], 1'b0};
                sc_c_s   = a[WIDTH-1];
            end
            OP_SHR1: begin
                sc_res_s = {1'b0, a[WIDTH-1:1]};
                sc_c_s   = a[0];
            end
            OP_ROR1: begin
                sc_res_s = {a[0], a[WIDTH-1:1]};
                sc_c_s   = a[0];
            end
            OP_ROL1: begin
                sc_res_s = {a[WIDTH-2:0], a[WIDTH-1]};
                sc_c_s   = a[WIDTH-1];
            end
            OP_EQ:   sc_res_s = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_GT:   sc_res_s = {{(WIDTH-1){1'b0}}, (a > b)};
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = start_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Select which result (single-cycle or engine) gets registered, if any.
    always_comb begin
        ld_en_s          = 1'b0;
        ld_res_s         = {WIDTH{1'b0}};
        ld_hi_s          = {WIDTH{1'b0}};
        ld_flags_s.c_out = 1'b0;
        ld_flags_s.err   = 1'b0;
        if (accept_s && !start_s) begin
            ld_en_s          = 1'b1;
            ld_res_s         = sc_res_s;
            ld_hi_s          = sc_hi_s;
            ld_flags_s.c_out = sc_c_s;
            ld_flags_s.err   = sc_err_s;
        end else if ((state_r == ST_BUSY) && md_done_s) begin
            ld_en_s          = 1'b1;
            ld_res_s         = md_lo_s;
            ld_hi_s          = md_hi_s;
            ld_flags_s.c_out = md_div_s ? 1'b0 : (|md_hi_s);
            ld_flags_s.err   = 1'b0;
        end else begin
            ld_en_s = 1'b0;
        end
        ld_flags_s.zero = (ld_res_s == {WIDTH{1'b0}});
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered handshake outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Result and flag registers; held until the next result is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= '{c_out: 1'b0, zero: 1'b0, err: 1'b0};
        end else if (ld_en_s) begin
            result_r    <= ld_res_s;
            result_hi_r <= ld_hi_s;
            flags_r     <= ld_flags_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign c_out     = flags_r.c_out;
    assign zero      = flags_r.zero;
    assign err       = flags_r.err;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vectors, a stall and a
// reset-during-BUSY scenario, then randomized traffic against an arithmetic
// reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int MASK = 255;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         c_out;
    logic         zero;
    logic         err;

    seq_alu #(.WIDTH(W), .MUL_DIV_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .c_out     (c_out),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       e;
        logic [7:0] lat;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cyc = 0;
    int   m_ready_at = 0;
    bit   m_pending = 1'b0;
    exp_t m_exp;

    // Expected outcome of one request, straight from the opcode definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t m;
        int ia = int'(x);
        int ib = int'(y);
        int r = 0;
        int h = 0;
        int c = 0;
        int e = 0;
        int lat = 1;
        case (op)
            4'd0:  r = ia & ib;
            4'd1:  r = ia | ib;
            4'd2:  r = ia ^ ib;
            4'd3:  r = MASK - (ia & ib);
            4'd4:  r = MASK - (ia | ib);
            4'd5:  r = MASK - (ia ^ ib);
            4'd6:  begin r = (ia + ib) % 256; c = (ia + ib) / 256; end
            4'd7:  begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
            4'd8:  begin r = (ia * ib) % 256; h = (ia * ib) / 256; c = (h != 0) ? 1 : 0; lat = W + 1; end
            4'd9:  begin
                if (ib == 0) begin r = MASK; h = ia; e = 1; end
                else begin r = ia / ib; h = ia % ib; lat = W + 1; end
            end
            4'd10: begin r = (ia * 2) % 256; c = ia / 128; end
            4'd11: begin r = ia / 2; c = ia % 2; end
            4'd12: begin r = ia / 2 + (ia % 2) * 128; c = ia % 2; end
            4'd13: begin r = (ia * 2) % 256 + ia / 128; c = ia / 128; end
            4'd14: r = (ia == ib) ? 1 : 0;
            4'd15: r = (ia > ib) ? 1 : 0;
            default: r = 0;
        endcase
        m.res = r[7:0];
        m.hi  = h[7:0];
        m.c   = (c != 0);
        m.z   = (r == 0);
        m.e   = (e != 0);
        m.lat = lat[7:0];
        return m;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    // Compare process: pins the model with hand-computed vectors, then on
    // every falling edge advances the model by the rising edge just past and
    // checks all DUT outputs against it.
    initial begin : compare
        exp_t p;
        bit   exp_ov;
        p = model(4'd6, 8'hFF, 8'h01);
        chk8("pin_add_res", p.res, 8'h00); chk1("pin_add_c", p.c, 1'b1);
        chk1("pin_add_z", p.z, 1'b1);      chk8("pin_add_lat", p.lat, 8'd1);
        p = model(4'd8, 8'hFF, 8'hFF);
        chk8("pin_mul_res", p.res, 8'h01); chk8("pin_mul_hi", p.hi, 8'hFE);
        chk1("pin_mul_c", p.c, 1'b1);      chk8("pin_mul_lat", p.lat, 8'd9);
        p = model(4'd9, 8'd100, 8'd7);
        chk8("pin_div_res", p.res, 8'd14); chk8("pin_div_hi", p.hi, 8'd2);
        chk1("pin_div_e", p.e, 1'b0);
        p = model(4'd9, 8'h05, 8'h00);
        chk8("pin_div0_res", p.res, 8'hFF); chk8("pin_div0_hi", p.hi, 8'h05);
        chk1("pin_div0_e", p.e, 1'b1);      chk8("pin_div0_lat", p.lat, 8'd1);
        p = model(4'd13, 8'h81, 8'h00);
        chk8("pin_rol_res", p.res, 8'h03); chk1("pin_rol_c", p.c, 1'b1);
        p = model(4'd7, 8'h03, 8'h05);
        chk8("pin_sub_res", p.res, 8'hFE); chk1("pin_sub_c", p.c, 1'b1);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pending = 1'b0;
                chk1("rst_out_valid", out_valid, 1'b0);
                chk8("rst_result", result, 8'h00);
                chk8("rst_result_hi", result_hi, 8'h00);
                chk1("rst_c_out", c_out, 1'b0);
                chk1("rst_zero", zero, 1'b0);
                chk1("rst_err", err, 1'b0);
            end else begin
                m_cyc++;
                if (m_pending) begin
                    if ((m_cyc - 1 >= m_ready_at) && out_ready) m_pending = 1'b0;
                end else if (in_valid) begin
                    m_exp      = model(opcode, a, b);
                    m_pending  = 1'b1;
                    m_ready_at = m_cyc + int'(m_exp.lat) - 1;
                end
                exp_ov = m_pending && (m_cyc >= m_ready_at);
                chk1("in_ready", in_ready, !m_pending);
                chk1("out_valid", out_valid, exp_ov);
                if (exp_ov) begin
                    chk8("result", result, m_exp.res);
                    chk8("result_hi", result_hi, m_exp.hi);
                    chk1("c_out", c_out, m_exp.c);
                    chk1("zero", zero, m_exp.z);
                    chk1("err", err, m_exp.e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_pending && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) begin
            $display("FAIL wait_idle: transaction never completed (cycle %0d)", m_cyc);
            $fatal(1, "bench stuck");
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        opcode   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_idle();
    endtask

    // Stimulus: inputs change just after each falling edge.
    initial begin : driver
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        opcode    = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        step();

        send(OP_ADD,  8'hFF, 8'h01);
        send(OP_MUL,  8'hFF, 8'hFF);
        send(OP_DIV,  8'd100, 8'd7);
        send(OP_DIV,  8'h05, 8'h00);
        send(OP_ROL1, 8'h81, 8'h00);
        send(OP_SUB,  8'h03, 8'h05);
        send(OP_MUL,  8'h00, 8'h37);
        send(OP_DIV,  8'hFF, 8'h01);
        send(OP_EQ,   8'h42, 8'h42);
        send(OP_GT,   8'h10, 8'h11);

        // Stall: consumer holds off while new requests are offered.
        wait_idle();
        out_ready = 1'b0;
        opcode    = OP_XOR;
        a         = 8'h5A;
        b         = 8'h3C;
        in_valid  = 1'b1;
        step();
        repeat (6) begin
            opcode = 4'($urandom_range(0, 15));
            a      = 8'($urandom);
            b      = 8'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();

        // Reset on the 4th BUSY cycle of a multiply.
        wait_idle();
        opcode   = OP_MUL;
        a        = 8'hC3;
        b        = 8'h5D;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (14) step();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            opcode    = 4'($urandom_range(0, 15));
            a         = 8'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
